// File: rtl/viterbi_frame_ctrl_if.sv
// Frame-control bus between the Viterbi frame sequencer and its surroundings.
// Carries:
//   - the symbol handshake;
//   - the ACS path metrics and the survivor-memory predecessors;
//   - the datapath enables;
//   - the decoded-bit stream.
// The sequencer sits on the slave modport; the upstream / datapath side uses master.
interface viterbi_frame_ctrl_if #(
    parameter int PM_W  = 8,
    parameter int CNT_W = 4
);
    // Frame start and symbol handshake
    logic              i_start;
    logic              i_sym_valid;
    logic              o_sym_ready;

    // ACS path metrics, one per trellis state
    logic [PM_W-1:0]   i_pm_00;
    logic [PM_W-1:0]   i_pm_01;
    logic [PM_W-1:0]   i_pm_10;
    logic [PM_W-1:0]   i_pm_11;

    // Survivor-memory readout: predecessor state for each current state
    logic [1:0]        i_bck_prv_st_00;
    logic [1:0]        i_bck_prv_st_01;
    logic [1:0]        i_bck_prv_st_10;
    logic [1:0]        i_bck_prv_st_11;

    // Datapath control
    logic              o_clr;
    logic              o_en_bmu;
    logic              o_en_acs;
    logic              o_en_memory;
    logic [CNT_W-1:0]  o_stage;

    // Decoded output and status
    logic              o_bit;
    logic              o_bit_valid;
    logic              o_busy;
    logic              o_done;

    // Upstream / datapath side
    modport master (
        output i_start, i_sym_valid,
        output i_pm_00, i_pm_01, i_pm_10, i_pm_11,
        output i_bck_prv_st_00, i_bck_prv_st_01, i_bck_prv_st_10, i_bck_prv_st_11,
        input  o_sym_ready, o_clr, o_en_bmu, o_en_acs, o_en_memory, o_stage,
        input  o_bit, o_bit_valid, o_busy, o_done
    );

    // Frame sequencer side
    modport slave (
        input  i_start, i_sym_valid,
        input  i_pm_00, i_pm_01, i_pm_10, i_pm_11,
        input  i_bck_prv_st_00, i_bck_prv_st_01, i_bck_prv_st_10, i_bck_prv_st_11,
        output o_sym_ready, o_clr, o_en_bmu, o_en_acs, o_en_memory, o_stage,
        output o_bit, o_bit_valid, o_busy, o_done
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer and traceback walker for a 4-state (K=3), rate-1/2 Viterbi decoder.
//
// Sequence:
//   IDLE -> CLEAR -> FILL -> SELECT -> TRACE -> DONE -> IDLE
//
// Per-state behaviour:
//   - FILL:   accepts FRAME_LEN symbol pairs and pulses the BMU/ACS/survivor
//             enables once per accepted symbol.
//   - SELECT: picks the traceback start state.
//   - TRACE:  walks the survivor memory from the newest stage back to stage 0.
//             One decoded bit is emitted per stage.
//
// Optional build macro VITERBI_TB_ZERO_TAIL_EN:
//   - Defined:   frames are assumed zero-terminated, so traceback always starts
//                at state 00 and the path metrics are ignored.
//   - Undefined: traceback starts at the minimum-metric state.
//                Ties go to the lowest state index.
//
// Reset rst is asynchronous and active-low.
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int PM_W      = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    viterbi_frame_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] FRAME_STAGES = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_STAGE   = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FILL   = 3'd2,
        ST_SELECT = 3'd3,
        ST_TRACE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stage_q, stage_d;          // FILL count, then traceback stage
    logic [CNT_W-1:0] tb_cnt_q, tb_cnt_d;        // bits still to emit in TRACE
    logic [1:0]       cur_state_q, cur_state_d;  // trellis state being traced
    logic             prime_q, prime_d;          // first TRACE cycle: memory read in flight
    logic             bit_q, bit_d;
    logic             bit_valid_q, bit_valid_d;

    logic             accept;
    logic [1:0]       prv_sel;
    logic [1:0]       start_state;

    // A symbol is taken only while filling and upstream offers one
    assign accept = (state_q == ST_FILL) && bus.i_sym_valid;

`ifdef VITERBI_TB_ZERO_TAIL_EN
    // Zero-terminated frames always end in state 00
    assign start_state = 2'b00;
`else
    logic [PM_W-1:0] min_pm;

    // Unsigned argmin over the four path metrics.
    // Strict less-than keeps the lower index on a tie.
    always_comb begin
        start_state = 2'b00;
        min_pm      = bus.i_pm_00;
        if (bus.i_pm_01 < min_pm) begin
            start_state = 2'b01;
            min_pm      = bus.i_pm_01;
        end
        if (bus.i_pm_10 < min_pm) begin
            start_state = 2'b10;
            min_pm      = bus.i_pm_10;
        end
        if (bus.i_pm_11 < min_pm) begin
            start_state = 2'b11;
            min_pm      = bus.i_pm_11;
        end
    end
`endif

    // Pick the survivor predecessor belonging to the state currently being traced
    always_comb begin
        prv_sel = bus.i_bck_prv_st_00;
        case (cur_state_q)
            2'b00:   prv_sel = bus.i_bck_prv_st_00;
            2'b01:   prv_sel = bus.i_bck_prv_st_01;
            2'b10:   prv_sel = bus.i_bck_prv_st_10;
            default: prv_sel = bus.i_bck_prv_st_11;
        endcase
    end

    // Next-state and counter logic for the frame sequence
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        tb_cnt_d    = tb_cnt_q;
        cur_state_d = cur_state_q;
        prime_d     = prime_q;
        bit_d       = bit_q;
        bit_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                stage_d = '0;
                state_d = ST_FILL;
            end

            ST_FILL: begin
                if (accept) begin
                    // The fill count stops at FRAME_LEN and never wraps
                    if (stage_q != FRAME_STAGES) begin
                        stage_d = stage_q + 1'b1;
                    end
                    if (stage_q == LAST_STAGE) begin
                        state_d = ST_SELECT;
                    end
                end
            end

            ST_SELECT: begin
                cur_state_d = start_state;
                tb_cnt_d    = FRAME_STAGES;
                stage_d     = LAST_STAGE;
                prime_d     = 1'b1;
                state_d     = ST_TRACE;
            end

            ST_TRACE: begin
                if (prime_q) begin
                    // Survivor memory has one cycle of read latency: wait for the data
                    prime_d = 1'b0;
                end else begin
                    bit_d       = cur_state_q[1];
                    bit_valid_d = 1'b1;
                    cur_state_d = prv_sel;
                    if (stage_q != '0) begin
                        stage_d = stage_q - 1'b1;
                    end
                    if (tb_cnt_q != '0) begin
                        tb_cnt_d = tb_cnt_q - 1'b1;
                    end
                    if (tb_cnt_q <= CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; an asynchronous reset abandons any frame in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            stage_q     <= '0;
            tb_cnt_q    <= '0;
            cur_state_q <= 2'b00;
            prime_q     <= 1'b0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            tb_cnt_q    <= tb_cnt_d;
            cur_state_q <= cur_state_d;
            prime_q     <= prime_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    // Control outputs are decoded from state.
    // Only the FILL enables also look at i_sym_valid.
    assign bus.o_sym_ready = (state_q == ST_FILL);
    assign bus.o_clr       = (state_q == ST_CLEAR);
    assign bus.o_en_bmu    = accept;
    assign bus.o_en_acs    = accept;
    assign bus.o_en_memory = accept || (state_q == ST_TRACE);
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_done      = (state_q == ST_DONE);
    assign bus.o_stage     = stage_q;
    assign bus.o_bit       = bit_q;
    assign bus.o_bit_valid = bit_valid_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl.
// The reference model derives, from the frame rules:
//   - the expected control waveform for every cycle of a frame;
//   - the expected decoded bits, by walking a survivor table from the chosen
//     start state.
// Also runs with VITERBI_TB_ZERO_TAIL_EN defined; the model then starts
// traceback at 00.
module tb_viterbi_frame_ctrl;

    localparam int FRAME_LEN = 8;
    localparam int PM_W      = 8;
    localparam int CNT_W     = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    viterbi_frame_ctrl_if #(.PM_W(PM_W), .CNT_W(CNT_W)) bus ();

    viterbi_frame_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .PM_W      (PM_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Survivor table indexed by stage and state, and the final path metrics
    logic [1:0]      prv_mem [16][4];
    logic [PM_W-1:0] pm      [4];
    bit              vpat    [64];

    // Survivor-memory model: predecessors for the stage on o_stage
    assign bus.i_bck_prv_st_00 = prv_mem[bus.o_stage][0];
    assign bus.i_bck_prv_st_01 = prv_mem[bus.o_stage][1];
    assign bus.i_bck_prv_st_10 = prv_mem[bus.o_stage][2];
    assign bus.i_bck_prv_st_11 = prv_mem[bus.o_stage][3];
    assign bus.i_pm_00 = pm[0];
    assign bus.i_pm_01 = pm[1];
    assign bus.i_pm_10 = pm[2];
    assign bus.i_pm_11 = pm[3];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] model_start();
`ifdef VITERBI_TB_ZERO_TAIL_EN
        return 2'b00;
`else
        int best = 0;
        for (int s = 1; s < 4; s++) begin
            if (pm[s] < pm[best]) best = s;
        end
        return 2'(best);
`endif
    endfunction

    function automatic logic [31:0] pack_outputs();
        return {19'd0, bus.o_bit, bus.o_sym_ready, bus.o_clr, bus.o_en_bmu,
                bus.o_en_acs, bus.o_en_memory, bus.o_busy, bus.o_done,
                bus.o_bit_valid, bus.o_stage};
    endfunction

    // Runs one frame.
    // Cycle 0 is the cycle i_start is offered.
    // abort_at > 0 pulls reset low after that cycle's checks.
    task automatic run_frame(input int fid, input bit poke, input int abort_at);
        int         acc;
        int         last_acc;
        int         done_cyc;
        int         acc_before [64];
        logic [1:0] st;
        logic [1:0] start_st;
        logic       exp_bit    [FRAME_LEN];
        logic [FRAME_LEN-1:0] bits_seen;
        logic [31:0] exp_v;
        logic [3:0]  exp_stage;
        bit          rdy, en, mem, bv;

        // Cycle of the FRAME_LEN-th accepted symbol
        acc      = 0;
        last_acc = 0;
        for (int c = 0; c < 64; c++) acc_before[c] = 0;
        for (int c = 2; c < 64; c++) begin
            acc_before[c] = acc;
            if (last_acc == 0 && vpat[c]) begin
                acc++;
                if (acc == FRAME_LEN) last_acc = c;
            end
        end
        done_cyc = last_acc + 11;

        // Traceback reference: newest stage first
        start_st = model_start();
        st       = start_st;
        for (int k = 0; k < FRAME_LEN; k++) begin
            exp_bit[k] = st[1];
            st         = prv_mem[FRAME_LEN - 1 - k][st];
        end
        bits_seen = '0;

        for (int c = 0; c <= done_cyc + 1; c++) begin
            @(negedge clk);
            bus.i_start     = (c == 0) ? 1'b1 :
                              (poke && c >= 2 && c < done_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.i_sym_valid = vpat[c];
            #1;
            rdy = (c >= 2) && (c <= last_acc);
            en  = rdy && vpat[c];
            mem = en || (c >= last_acc + 2 && c <= last_acc + 10);
            bv  = (c >= last_acc + 4) && (c <= last_acc + 11);
            if (c <= 1)                  exp_stage = 4'd0;
            else if (c <= last_acc)      exp_stage = 4'(acc_before[c]);
            else if (c == last_acc + 1)  exp_stage = 4'(FRAME_LEN);
            else if (c == last_acc + 2)  exp_stage = 4'(FRAME_LEN - 1);
            else if (c <= last_acc + 10) exp_stage = 4'(FRAME_LEN - 1 - (c - (last_acc + 3)));
            else                         exp_stage = 4'd0;
            exp_v = {19'd0, bus.o_bit, rdy, (c == 1), en, en, mem,
                     (c >= 1 && c <= done_cyc), (c == done_cyc), bv, exp_stage};
            // o_bit itself is only meaningful while valid; it is compared separately
            check_eq($sformatf("ctl f%0d c%0d", fid, c), pack_outputs(), exp_v);
            if (bv) begin
                check_eq($sformatf("bit f%0d k%0d", fid, c - (last_acc + 4)),
                         32'(bus.o_bit), 32'(exp_bit[c - (last_acc + 4)]));
                bits_seen[FRAME_LEN - 1 - (c - (last_acc + 4))] = bus.o_bit;
            end
            if (abort_at != 0 && c == abort_at) begin
                rst = 1'b0;
                bus.i_start = 1'b0;
                #1;
                check_eq($sformatf("abort f%0d", fid), pack_outputs(), 32'd0);
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    check_eq($sformatf("abort_hold f%0d h%0d", fid, h), pack_outputs(), 32'd0);
                end
                rst = 1'b1;
                $display("frame %0d aborted at cycle %0d start=%0d", fid, c, start_st);
                return;
            end
        end
        bus.i_start = 1'b0;
        $display("frame %0d last_accept=%0d done=%0d start=%0d bits(stage7..0)=%b",
                 fid, last_acc, done_cyc, start_st, bits_seen);
    endtask

    task automatic fill_valid(input int mode);
        for (int c = 0; c < 64; c++) begin
            case (mode)
                0:       vpat[c] = 1'b1;
                1:       vpat[c] = (c % 2 == 0);
                default: vpat[c] = (c >= 40) ? 1'b1 : ($urandom_range(0, 9) < 6);
            endcase
        end
    endtask

    task automatic set_prv_uniform(input logic [1:0] p0, input logic [1:0] p1,
                                   input logic [1:0] p2, input logic [1:0] p3);
        for (int s = 0; s < 16; s++) begin
            prv_mem[s][0] = p0;
            prv_mem[s][1] = p1;
            prv_mem[s][2] = p2;
            prv_mem[s][3] = p3;
        end
    endtask

    task automatic randomize_frame();
        for (int s = 0; s < 16; s++)
            for (int q = 0; q < 4; q++) prv_mem[s][q] = 2'($urandom_range(0, 3));
        for (int q = 0; q < 4; q++) pm[q] = PM_W'($urandom_range(0, 15));
        fill_valid(2);
    endtask

    initial begin
        int u [FRAME_LEN];
        logic [1:0] enc_prv;

        bus.i_start     = 1'b0;
        bus.i_sym_valid = 1'b0;
        set_prv_uniform(2'b00, 2'b00, 2'b00, 2'b00);
        for (int q = 0; q < 4; q++) pm[q] = '0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset", pack_outputs(), 32'd0);
        rst = 1'b1;

        // Frame 1: steady symbols, metric tie between 01 and 10, all-zero survivors
        pm[0] = 8'd9; pm[1] = 8'd3; pm[2] = 8'd3; pm[3] = 8'd7;
        set_prv_uniform(2'b00, 2'b00, 2'b00, 2'b00);
        fill_valid(0);
        run_frame(1, 1'b0, 0);

        // Frame 2: alternating valid, state 11 minimal and self-looping
        pm[3] = 8'd1;
        set_prv_uniform(2'b00, 2'b00, 2'b00, 2'b11);
        fill_valid(1);
        run_frame(2, 1'b0, 0);

        // Frame 3: survivors encode the path of input 1,0,1,1,0,0,1,0
        u = '{1, 0, 1, 1, 0, 0, 1, 0};
        for (int k = 0; k < FRAME_LEN; k++) begin
            enc_prv = {(k >= 1) ? 1'(u[k-1]) : 1'b0, (k >= 2) ? 1'(u[k-2]) : 1'b0};
            for (int q = 0; q < 4; q++) prv_mem[k][q] = enc_prv;
        end
        pm[0] = 8'd5; pm[1] = 8'd0; pm[2] = 8'd6; pm[3] = 8'd7;
        fill_valid(0);
        run_frame(3, 1'b0, 0);

        // Frame 4: i_start pulsed throughout FILL and TRACE
        randomize_frame();
        run_frame(4, 1'b1, 0);

        // Randomized frames
        for (int f = 5; f < 13; f++) begin
            randomize_frame();
            run_frame(f, f[0], 0);
        end

        // Reset during TRACE after three bits, then a clean frame
        fill_valid(0);
        run_frame(13, 1'b0, 9 + 6);
        randomize_frame();
        run_frame(14, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
